// File: rtl/rs_syndrome_calc_pkg.sv
// Shared GF(2^m) constants, types and elaboration-time helpers for the RS syndrome datapath.
package rs_syndrome_calc_pkg;

  localparam int unsigned SYMB_WIDTH        = 8;
  localparam int unsigned POLY              = 285;
  localparam int unsigned N_LEN             = 255;
  localparam int unsigned K_LEN             = 239;
  localparam int unsigned ROOTS_NUM         = N_LEN - K_LEN;
  localparam int unsigned BUS_WIDTH_IN_SYMB = 4;
  localparam int unsigned FIRST_ROOT        = 1;
  localparam int unsigned GF_MAX_W          = 16;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t syndrome_vec_t [ROOTS_NUM-1:0];
  typedef logic [GF_MAX_W-1:0][GF_MAX_W-1:0] gf_matrix_t;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_FIXUP,
    ST_HOLD
  } state_t;

  // alpha^exp in a field of the given width and primitive polynomial
  function automatic logic [GF_MAX_W-1:0] gf_pow(input int unsigned exp,
                                                 input int unsigned width,
                                                 input int unsigned poly);
    logic [GF_MAX_W:0] v;
    v = (GF_MAX_W+1)'(1);
    for (int unsigned i = 0; i < exp % ((1 << width) - 1); i++) begin
      v = v << 1;
      if (v[width]) v = v ^ (GF_MAX_W+1)'(poly);
    end
    return v[GF_MAX_W-1:0];
  endfunction

  // Row i holds alpha^exp * x^i, so the product is the XOR of rows selected by input bits
  function automatic gf_matrix_t gf_const_mult_matrix(input int unsigned exp,
                                                      input int unsigned width,
                                                      input int unsigned poly);
    gf_matrix_t m;
    m = '0;
    for (int unsigned i = 0; i < width; i++) m[i] = gf_pow(exp + i, width, poly);
    return m;
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Input beat stream and syndrome result stream of the RS syndrome calculator.
interface rs_syndrome_calc_if #(
  parameter int unsigned SYMB_WIDTH        = rs_syndrome_calc_pkg::SYMB_WIDTH,
  parameter int unsigned BUS_WIDTH_IN_SYMB = rs_syndrome_calc_pkg::BUS_WIDTH_IN_SYMB,
  parameter int unsigned ROOTS_NUM         = rs_syndrome_calc_pkg::ROOTS_NUM
);
  logic                                    s_tvalid;
  logic                                    s_tready;
  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] s_tdata;
  logic [BUS_WIDTH_IN_SYMB-1:0]            s_tkeep;
  logic                                    s_tlast;
  logic                                    m_tvalid;
  logic                                    m_tready;
  logic [ROOTS_NUM*SYMB_WIDTH-1:0]         m_tdata;
  logic                                    m_terr;
  logic                                    m_tlen_err;

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_terr, m_tlen_err
  );

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_terr, m_tlen_err
  );
endinterface

// File: rtl/rs_syndrome_calc_gf_const_mult.sv
// Combinational multiply of one symbol by the constant alpha^EXP via an XOR matrix.
module gf_const_mult #(
  parameter int unsigned SYMB_WIDTH = rs_syndrome_calc_pkg::SYMB_WIDTH,
  parameter int unsigned POLY       = rs_syndrome_calc_pkg::POLY,
  parameter int unsigned EXP        = 0
) (
  input  logic [SYMB_WIDTH-1:0] din,
  output logic [SYMB_WIDTH-1:0] dout
);
  import rs_syndrome_calc_pkg::*;

  localparam gf_matrix_t MATRIX = gf_const_mult_matrix(EXP, SYMB_WIDTH, POLY);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < SYMB_WIDTH; i++)
      dout ^= MATRIX[i][SYMB_WIDTH-1:0] & {SYMB_WIDTH{din[i]}};
  end
endmodule

// File: rtl/rs_syndrome_calc.sv
// Streaming RS syndrome calculator: W symbols per beat, pad fixup on a partial last beat,
// nonzero-syndrome and frame-length flags on the result.
module rs_syndrome_calc #(
  parameter int unsigned SYMB_WIDTH        = rs_syndrome_calc_pkg::SYMB_WIDTH,
  parameter int unsigned POLY              = rs_syndrome_calc_pkg::POLY,
  parameter int unsigned N_LEN             = rs_syndrome_calc_pkg::N_LEN,
  parameter int unsigned K_LEN             = rs_syndrome_calc_pkg::K_LEN,
  parameter int unsigned BUS_WIDTH_IN_SYMB = rs_syndrome_calc_pkg::BUS_WIDTH_IN_SYMB,
  parameter int unsigned FIRST_ROOT        = rs_syndrome_calc_pkg::FIRST_ROOT
) (
  input logic               aclk,
  input logic               aresetn,
  rs_syndrome_calc_if.slave axis
);
  import rs_syndrome_calc_pkg::*;

  localparam int unsigned W         = BUS_WIDTH_IN_SYMB;
  localparam int unsigned ROOTS_NUM = N_LEN - K_LEN;
  localparam int unsigned Q         = (1 << SYMB_WIDTH) - 1;
  localparam int unsigned CNT_W     = $clog2(N_LEN + W);
  localparam int unsigned KC_W      = $clog2(W + 1);

  typedef logic [SYMB_WIDTH-1:0] sym_t;

  state_t                          state;
  sym_t                            acc        [ROOTS_NUM];
  sym_t                            acc_scaled [ROOTS_NUM];
  sym_t                            acc_next   [ROOTS_NUM];
  sym_t                            lane_term  [ROOTS_NUM][W];
  sym_t                            pad_cand   [ROOTS_NUM][W+1];
  sym_t                            lane_d     [W];
  logic [ROOTS_NUM*SYMB_WIDTH-1:0] fixed_flat;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                cnt_next;
  logic [CNT_W:0]                  cnt_sum;
  logic [KC_W-1:0]                 keep_cnt;
  logic [KC_W-1:0]                 pad;
  logic [W-1:0]                    keep_inc;
  logic                            accept;

  assign accept   = axis.s_tvalid & axis.s_tready;
  assign keep_inc = axis.s_tkeep + W'(1);

  always_comb begin
    keep_cnt = '0;
    for (int unsigned k = 0; k < W; k++) begin
      lane_d[k] = axis.s_tkeep[k] ? axis.s_tdata[k*SYMB_WIDTH +: SYMB_WIDTH] : '0;
      keep_cnt += KC_W'(axis.s_tkeep[k]);
    end
  end

  // Lane 0 is the highest-degree symbol of the beat, so it carries the largest power.
  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_root
    localparam int unsigned R = FIRST_ROOT + j;
    gf_const_mult #(.SYMB_WIDTH(SYMB_WIDTH), .POLY(POLY), .EXP((R * W) % Q))
      u_beat (.din(acc[j]), .dout(acc_scaled[j]));
    for (genvar k = 0; k < W; k++) begin : g_lane
      gf_const_mult #(.SYMB_WIDTH(SYMB_WIDTH), .POLY(POLY), .EXP((R * (W - 1 - k)) % Q))
        u_lane (.din(lane_d[k]), .dout(lane_term[j][k]));
    end
    // Zero lanes of a short last beat act as trailing symbols; undo their x^pad shift.
    for (genvar p = 0; p <= W; p++) begin : g_pad
      gf_const_mult #(.SYMB_WIDTH(SYMB_WIDTH), .POLY(POLY), .EXP((Q - (R * p) % Q) % Q))
        u_pad (.din(acc[j]), .dout(pad_cand[j][p]));
    end
  end

  always_comb begin
    fixed_flat = '0;
    for (int unsigned j = 0; j < ROOTS_NUM; j++) begin
      acc_next[j] = acc_scaled[j];
      for (int unsigned k = 0; k < W; k++) acc_next[j] ^= lane_term[j][k];
      fixed_flat[j*SYMB_WIDTH +: SYMB_WIDTH] = pad_cand[j][pad];
    end
    cnt_sum  = {1'b0, cnt} + (CNT_W+1)'(keep_cnt);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= ST_ACCUM;
      cnt             <= '0;
      pad             <= '0;
      for (int unsigned j = 0; j < ROOTS_NUM; j++) acc[j] <= '0;
      axis.s_tready   <= 1'b1;
      axis.m_tvalid   <= 1'b0;
      axis.m_tdata    <= '0;
      axis.m_terr     <= 1'b0;
      axis.m_tlen_err <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: if (accept) begin
          for (int unsigned j = 0; j < ROOTS_NUM; j++) acc[j] <= acc_next[j];
          cnt <= cnt_next;
          if (axis.s_tlast) begin
            pad           <= KC_W'(W) - keep_cnt;
            axis.s_tready <= 1'b0;
            state         <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          axis.m_tdata    <= fixed_flat;
          axis.m_terr     <= |fixed_flat;
          axis.m_tlen_err <= (cnt != CNT_W'(N_LEN));
          axis.m_tvalid   <= 1'b1;
          state           <= ST_HOLD;
        end
        ST_HOLD: if (axis.m_tready) begin
          for (int unsigned j = 0; j < ROOTS_NUM; j++) acc[j] <= '0;
          cnt           <= '0;
          axis.m_tvalid <= 1'b0;
          axis.s_tready <= 1'b1;
          state         <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  keep_contig_a: assert property (@(posedge aclk) disable iff (!aresetn)
    accept |-> ((axis.s_tkeep & keep_inc) == '0));

endmodule
